block_mem: RTL and testbench

Block-granular main-memory model and controller sitting directly downstream of the parameterised set-associative cache. Serves the cache's block read (refill) and block write (write-back) requests on the `MEM_*` interface, with a configurable initial access latency followed by one word transferred per cycle. `BUSYWAIT` is asserted from the first cycle of a request until the block is complete. This gives the cache miss path realistic, parameter-dependent stall behaviour.

---
 rtl/block_mem.sv | 98 +++++++++
 tb/tb_block_mem.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/block_mem.sv
// block_mem: block-granular main memory with fixed access latency then one word per cycle.
module block_mem #(
    parameter int BLOCK_SIZE   = 4,
    parameter int DEPTH_BLOCKS = 256,
    parameter int LATENCY      = 5,
    localparam int OFFSET_BITS = $clog2(BLOCK_SIZE),
    localparam int ADDR_BITS   = 32 - OFFSET_BITS,
    localparam int IDX_BITS    = $clog2(DEPTH_BLOCKS)
) (
    input  logic                    CLOCK,
    input  logic                    RESET,
    input  logic                    READ_EN,
    input  logic                    WRITE_EN,
    input  logic [ADDR_BITS-1:0]    ADDR,
    input  logic [32*BLOCK_SIZE-1:0] WRITE_DATA,
    output logic [32*BLOCK_SIZE-1:0] READ_DATA,
    output logic                    BUSYWAIT
);
    localparam int CW = $clog2(LATENCY + 1);
    localparam int WW = OFFSET_BITS > 0 ? OFFSET_BITS : 1;
    localparam int MW = IDX_BITS + OFFSET_BITS;
    localparam logic [1:0] S_IDLE = 2'd0, S_WAIT = 2'd1, S_XFER = 2'd2, S_DONE = 2'd3;
    localparam logic [CW-1:0] LAT_LAST = CW'(LATENCY - 1);
    localparam logic [WW-1:0] WC_LAST = WW'(BLOCK_SIZE - 1);

    logic [31:0] mem [DEPTH_BLOCKS*BLOCK_SIZE];
    logic [1:0] state_q, state_d;
    logic [CW-1:0] lat_q, lat_d;
    logic [WW-1:0] wc_q, wc_d;
    logic write_q, write_d;
    logic [IDX_BITS-1:0] idx_q, idx_d;
    logic [32*BLOCK_SIZE-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [MW-1:0] maddr;
    logic unused_addr;

    // Upper block-address bits alias onto the stored blocks.
    assign unused_addr = ^ADDR[ADDR_BITS-1:IDX_BITS];

    if (OFFSET_BITS > 0) begin : g_off
        assign maddr = {idx_q, wc_q};
    end else begin : g_nooff
        assign maddr = idx_q;
    end

    assign BUSYWAIT = (state_q == S_IDLE && (READ_EN || WRITE_EN)) || state_q == S_WAIT || state_q == S_XFER;
    assign READ_DATA = rdata_q;

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        wc_d    = wc_q;
        write_d = write_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: if (WRITE_EN || READ_EN) begin
                state_d = S_WAIT;
                lat_d   = '0;
                write_d = WRITE_EN;
                idx_d   = ADDR[IDX_BITS-1:0];
                if (WRITE_EN) wdata_d = WRITE_DATA;
            end
            S_WAIT: if (lat_q == LAT_LAST) begin
                state_d = S_XFER;
                wc_d    = '0;
            end else lat_d = lat_q + 1'b1;
            S_XFER: begin
                if (!write_q) rdata_d[32*wc_q +: 32] = mem[maddr];
                if (wc_q == WC_LAST) state_d = S_DONE;
                else wc_d = wc_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            lat_q   <= '0;
            wc_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            wc_q    <= wc_d;
            rdata_q <= rdata_d;
            write_q <= write_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
        end
    end

    // Storage survives reset; only the word in flight at the reset edge is dropped.
    always_ff @(posedge CLOCK) begin
        if (!RESET && state_q == S_XFER && write_q) mem[maddr] <= wdata_q[32*wc_q +: 32];
    end
endmodule

// File: tb/tb_block_mem.sv
// tb_block_mem: directed checks of block_mem latency, handshake, aliasing and reset behaviour.
module tb_block_mem;
    logic clk, rst;
    logic re_a, we_a, busy_a;
    logic [29:0] addr_a;
    logic [127:0] wd_a, rd_a;
    logic re_b, we_b, busy_b;
    logic [28:0] addr_b;
    logic [255:0] wd_b, rd_b;
    int errors = 0, checks = 0;

    block_mem dut_a (
        .CLOCK(clk), .RESET(rst), .READ_EN(re_a), .WRITE_EN(we_a), .ADDR(addr_a),
        .WRITE_DATA(wd_a), .READ_DATA(rd_a), .BUSYWAIT(busy_a)
    );

    block_mem #(.BLOCK_SIZE(8), .DEPTH_BLOCKS(256), .LATENCY(1)) dut_b (
        .CLOCK(clk), .RESET(rst), .READ_EN(re_b), .WRITE_EN(we_b), .ADDR(addr_b),
        .WRITE_DATA(wd_b), .READ_DATA(rd_b), .BUSYWAIT(busy_b)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic txn_a(input logic w, input logic r, input logic [29:0] a, input logic [127:0] d, output int n);
        we_a = w; re_a = r; addr_a = a; wd_a = d;
        #1;
        n = 0;
        while (busy_a && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic txn_b(input logic w, input logic r, input logic [28:0] a, input logic [255:0] d, output int n);
        we_b = w; re_b = r; addr_b = a; wd_b = d;
        #1;
        n = 0;
        while (busy_b && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic idle;
        we_a = 0; re_a = 0; we_b = 0; re_b = 0;
        @(negedge clk);
    endtask

    initial begin
        int n;
        logic [127:0] d1, d2, o, nw;
        logic [255:0] p;
        d1 = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
        d2 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        o  = {32'hA3A3_A3A3, 32'hA2A2_A2A2, 32'hA1A1_A1A1, 32'hA0A0_A0A0};
        nw = {32'hB3B3_B3B3, 32'hB2B2_B2B2, 32'hB1B1_B1B1, 32'hB0B0_B0B0};
        for (int i = 0; i < 8; i++) p[32*i +: 32] = 32'h1000_0001 * (i + 1);
        rst = 1; re_a = 0; we_a = 0; addr_a = 0; wd_a = 0;
        re_b = 0; we_b = 0; addr_b = 0; wd_b = 0;
        repeat (2) @(negedge clk);
        check("reset_busy_a", busy_a, 0);
        check("reset_rd_a", rd_a, 0);
        check("reset_busy_b", busy_b, 0);
        check("reset_rd_b", rd_b, 0);
        rst = 0;
        @(negedge clk);

        txn_a(0, 1, 30'd3, 0, n);
        check("rd3_busy_cycles", n, 10);
        check("rd3_data", rd_a, 0);
        idle();

        txn_a(1, 0, 30'h12, d1, n);
        check("wr12_busy_cycles", n, 10);
        we_a = 0; re_a = 1;
        #1;
        check("done_ignores_en", busy_a, 0);
        @(negedge clk);
        txn_a(0, 1, 30'h12, 0, n);
        check("rd12_busy_cycles", n, 10);
        check("rd12_data", rd_a, d1);
        idle();

        txn_a(1, 1, 30'd7, {16{8'h5A}}, n);
        check("both_en_busy_cycles", n, 10);
        check("rd_holds_over_write", rd_a, d1);
        idle();
        txn_a(0, 1, 30'd7, 0, n);
        check("rd7_data", rd_a, {16{8'h5A}});
        idle();

        txn_a(1, 0, 30'h105, d2, n);
        idle();
        txn_a(0, 1, 30'h005, 0, n);
        check("alias_data", rd_a, d2);
        idle();

        re_a = 1; addr_a = 30'h12;
        @(negedge clk);
        addr_a = 30'd3; re_a = 0;
        n = 1;
        while (busy_a && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("midchange_busy_cycles", n, 10);
        check("midchange_data", rd_a, d1);
        idle();

        txn_a(1, 0, 30'h20, o, n);
        idle();
        we_a = 1; addr_a = 30'h20; wd_a = nw;
        repeat (8) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0; we_a = 0;
        #1;
        check("abort_busy", busy_a, 0);
        check("abort_rd_cleared", rd_a, 0);
        @(negedge clk);
        txn_a(0, 1, 30'h20, 0, n);
        check("abort_rd_busy_cycles", n, 10);
        check("abort_partial_data", rd_a, {o[127:64], nw[63:0]});
        idle();

        txn_b(1, 0, 29'd9, p, n);
        check("b_wr_busy_cycles", n, 10);
        idle();
        txn_b(0, 1, 29'd9, 0, n);
        check("b_rd_busy_cycles", n, 10);
        check("b_rd_data", rd_b, p);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
